reg_write_arbiter: RTL

- Shares one bank of NREG enable-gated registers among NREQ write requesters.
- Arbitrates round-robin and returns a registered one-cycle grant to the winning requester.
- Drives the bank's per-register enables, the shared data bus and the shared synchronous clear.
- Sits between the datapath write sources and the register instances. It is the only driver of their en, d and clr inputs.

---
 rtl/regarb_pkg.sv | 16 +
 rtl/reg_write_arbiter_rr_pick.sv | 31 +++
 rtl/reg_write_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/regarb_pkg.sv
// Shared types and helpers for the register-bank write arbiter.
package regarb_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    CLEAR = 2'd2
  } state_e;

  function automatic logic [31:0] onehot(input int unsigned idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational winner picker. Round-robin from ptr by default.
// Define REGARB_FIXED_PRIO_EN for fixed priority, where the lowest index wins and ptr is ignored.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         elig,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] win,
  output logic                    vld
);
  localparam int IW = $clog2(NREQ);

  always_comb begin
    int j;
    win = '0;
    vld = 1'b0;
    j   = 0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef REGARB_FIXED_PRIO_EN
      j = i;
`else
      j = (int'(ptr) + i) % NREQ;
`endif
      if (!vld && elig[j]) begin
        vld = 1'b1;
        win = IW'(j);
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates NREQ write requesters onto one bank of NREG registers, with registered outputs.
// The optional macro REGARB_FIXED_PRIO_EN selects fixed priority and removes the round-robin pointer.
module reg_write_arbiter
  import regarb_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREQ = 4,
  parameter int NREG = 4
) (
  input  logic                         clk,
  input  logic                         clr_n,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*$clog2(NREG)-1:0] addr,
  input  logic [NREQ*N-1:0]            wdata,
  input  logic                         bank_clr,
  output logic [NREQ-1:0]              gnt,
  output logic [NREG-1:0]              reg_en,
  output logic [N-1:0]                 reg_d,
  output logic                         reg_clr,
  output logic                         busy
);
  localparam int AW = $clog2(NREG);
  localparam int IW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d, elig;
  logic [NREG-1:0] reg_en_q, reg_en_d;
  logic [N-1:0]    reg_d_q, reg_d_d;
  logic            reg_clr_q, reg_clr_d;
  logic [IW-1:0]   ptr, win;
  logic            win_vld;
  logic [AW-1:0]   win_addr;

  // The requester granted this cycle sits out one edge so it can load its next item.
  assign elig = req & ~gnt_q;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .elig (elig),
    .ptr  (ptr),
    .win  (win),
    .vld  (win_vld)
  );

  assign win_addr = addr[int'(win)*AW +: AW];

  always_comb begin
    state_d   = IDLE;
    gnt_d     = '0;
    reg_en_d  = '0;
    reg_d_d   = '0;
    reg_clr_d = 1'b0;
    if (bank_clr && state_q != CLEAR) begin
      state_d   = CLEAR;
      reg_clr_d = 1'b1;
    end else if (win_vld) begin
      state_d = GRANT;
      gnt_d   = NREQ'(onehot(int'(win)));
      // Out-of-range targets are still granted but enable nothing.
      if (int'(win_addr) < NREG) reg_en_d = NREG'(onehot(int'(win_addr)));
      reg_d_d = wdata[int'(win)*N +: N];
    end
  end

`ifdef REGARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [IW-1:0] ptr_q, ptr_d;

  assign ptr = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (state_d == GRANT) ptr_d = (int'(win) == NREQ-1) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      reg_en_q  <= '0;
      reg_d_q   <= '0;
      reg_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      reg_en_q  <= reg_en_d;
      reg_d_q   <= reg_d_d;
      reg_clr_q <= reg_clr_d;
    end
  end

  assign gnt     = gnt_q;
  assign reg_en  = reg_en_q;
  assign reg_d   = reg_d_q;
  assign reg_clr = reg_clr_q;
  assign busy    = (state_q != IDLE);

endmodule
